// File: rtl/light_pkg.sv
// Shared definitions for the XOR-light built-in self-test.
// Holds the FSM state encoding, the vector count and the Gray-ordered
// stimulus table (00,10,11,01,00 as {x1,x2}), plus lookup helpers.
package light_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int          NUM_VEC  = 5;
    localparam logic [2:0]  LAST_IDX = 3'd4;

    // Bit i of each mask is the switch value for vector i.
    localparam logic [4:0]  VEC_X1 = 5'b00110;
    localparam logic [4:0]  VEC_X2 = 5'b01100;

    function automatic logic vec_x1(input logic [2:0] idx);
        return VEC_X1[idx];
    endfunction

    function automatic logic vec_x2(input logic [2:0] idx);
        return VEC_X2[idx];
    endfunction

endpackage

// File: rtl/light_selftest_timer.sv
// Loadable down-counter shared by the SETTLE and HOLD phases.
// Ports: clk, rst_n (sync, active-low), load_i/load_val_i load a new count,
// expired_o is high while the count is zero. The count stops at zero.
module light_selftest_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/light_selftest.sv
// Built-in self-test for the two-switch XOR light. Drives x1/x2 through the
// Gray vector table, waits SETTLE_CYCLES, samples f_in against x1^x2, dwells
// HOLD_CYCLES, and reports mismatch count and first failing index.
// Ports: clk, rst_n (sync, active-low), start, f_in (light output) ->
//        x1_out, x2_out, busy, done, pass, err_count[2:0], first_err_idx[2:0].
// Option: define LIGHT_SELFTEST_FAIL_STOP_EN to end the run at the first mismatch.
module light_selftest
    import light_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       x1_out,
    output logic       x2_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [2:0] first_err_idx
);

    // Timer loads count "cycles remaining minus one"; phase ends when it reads zero.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic             HOLD_EN     = (HOLD_CYCLES > 0);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             x1_q, x1_d, x2_q, x2_d;
    logic [2:0]       err_q, err_d;
    logic [2:0]       first_q, first_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_exp_s;
    logic             mismatch_s;
    logic             advance_s;

    light_selftest_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load_s),
        .load_val_i(tmr_val_s),
        .expired_o (tmr_exp_s)
    );

    assign mismatch_s = (f_in != (x1_q ^ x2_q));

    // Next-state, vector stepping and error bookkeeping.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        err_d      = err_q;
        first_d    = first_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        advance_s  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    idx_d      = 3'd0;
                    x1_d       = vec_x1(3'd0);
                    x2_d       = vec_x2(3'd0);
                    err_d      = 3'd0;
                    first_d    = 3'd0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETTLE_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (tmr_exp_s) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    // At most five vectors, so the 3-bit count cannot wrap.
                    err_d = err_q + 3'd1;
                    if (err_q == 3'd0) begin
                        first_d = idx_q;
                    end else begin
                        first_d = first_q;
                    end
                end else begin
                    err_d = err_q;
                end
`ifdef LIGHT_SELFTEST_FAIL_STOP_EN
                if (mismatch_s) begin
                    state_d = ST_DONE;
                end else if (HOLD_EN) begin
`else
                if (HOLD_EN) begin
`endif
                    state_d    = ST_HOLD;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LOAD;
                end else begin
                    // Zero dwell: step to the next vector straight from CHECK.
                    advance_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_exp_s) begin
                    advance_s = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New vector is applied on the same edge that re-enters SETTLE.
        if (advance_s) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                state_d    = ST_SETTLE;
                idx_d      = idx_q + 3'd1;
                x1_d       = vec_x1(idx_q + 3'd1);
                x2_d       = vec_x2(idx_q + 3'd1);
                tmr_load_s = 1'b1;
                tmr_val_s  = SETTLE_LOAD;
            end
        end else begin
            idx_d = idx_d;
        end
    end

    // Status flags are computed from the next state so they register alongside it.
    always_comb begin
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == 3'd0);
    end

    // State and output registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            x1_q    <= 1'b0;
            x2_q    <= 1'b0;
            err_q   <= 3'd0;
            first_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            err_q   <= err_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign x1_out        = x1_q;
    assign x2_out        = x2_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_light_selftest.sv
// Self-checking bench for light_selftest (SETTLE_CYCLES=2, HOLD_CYCLES=4).
// The attached "light" is x1^x2 corrupted by a 4-entry fault table indexed by
// {x1,x2}; the reference model walks the vector list and predicts every cycle.
module tb_light_selftest;

    localparam int S   = 2;
    localparam int H   = 4;
    localparam int PER = S + 1 + H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       f_in;
    logic       x1_out, x2_out, busy, done, pass;
    logic [2:0] err_count, first_err_idx;
    logic [3:0] fault = 4'b0000;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    bit ref_x1 [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit ref_x2 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    assign f_in = (x1_out ^ x2_out) ^ fault[{x1_out, x2_out}];

    light_selftest #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .f_in         (f_in),
        .x1_out       (x1_out),
        .x2_out       (x2_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_err_idx(first_err_idx)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_x1"}, {7'd0, x1_out}, 8'd0);
        chk({tag, "_x2"}, {7'd0, x2_out}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_pass"}, {7'd0, pass}, 8'd0);
        chk({tag, "_err"}, {5'd0, err_count}, 8'd0);
        chk({tag, "_first"}, {5'd0, first_err_idx}, 8'd0);
    endtask

    // One full run with fault table f; optional extra start pulse sampled at cycle pulse_at.
    task automatic run(input logic [3:0] f, input int pulse_at, input string tag);
        int  n_err   = 0;
        int  first   = 0;
        int  last    = 4;
        int  done_c  = 5 * PER;
        for (int k = 0; k < 5; k++) begin
            if (f[{ref_x1[k], ref_x2[k]}]) begin
                if (n_err == 0) first = k;
                n_err++;
`ifdef LIGHT_SELFTEST_FAIL_STOP_EN
                if (n_err == 1) begin
                    done_c = k * PER + S + 1;
                    last   = k;
                end
`endif
            end
        end
`ifdef LIGHT_SELFTEST_FAIL_STOP_EN
        if (n_err > 1) n_err = 1;
`endif
        @(negedge clk);
        fault = f;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= done_c; c++) begin
            #1;
            if (c < done_c) begin
                chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
                chk({tag, "_done_early"}, {7'd0, done}, 8'd0);
                chk({tag, "_x1"}, {7'd0, x1_out}, {7'd0, ref_x1[c / PER]});
                chk({tag, "_x2"}, {7'd0, x2_out}, {7'd0, ref_x2[c / PER]});
            end else begin
                chk({tag, "_done"}, {7'd0, done}, 8'd1);
                chk({tag, "_busy_end"}, {7'd0, busy}, 8'd0);
                chk({tag, "_pass"}, {7'd0, pass}, (n_err == 0) ? 8'd1 : 8'd0);
                chk({tag, "_err"}, {5'd0, err_count}, 8'(n_err));
                chk({tag, "_first"}, {5'd0, first_err_idx}, 8'(first));
                chk({tag, "_x1_end"}, {7'd0, x1_out}, {7'd0, ref_x1[last]});
                chk({tag, "_x2_end"}, {7'd0, x2_out}, {7'd0, ref_x2[last]});
            end
            @(negedge clk);
            start = (c + 1 == pulse_at);
            if (c < done_c) @(posedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct light, stuck-at-0, XNOR.
        run(4'b0000, -1, "xor_ok");
        run(4'b0110, -1, "stuck0");
        run(4'b1111, -1, "xnor");

        // Restart from DONE with a start pulse landing in idx 2 (ignored).
        run(4'b0000, 2 * PER + 2, "start_busy");

        // Reset mid-run during idx 2.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * PER + 1) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_zero("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({"post_rst_idle"}, {7'd0, busy}, 8'd0);
        run(4'b0000, -1, "after_rst");

        // Random fault tables.
        for (int r = 0; r < 6; r++) begin
            run(4'($urandom_range(0, 15)), -1, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
